// File: rtl/mult_pkg.sv
// mult_pkg: shared width defaults and partial-product row generation for the array multiplier.
package mult_pkg;
  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH = 16;
  typedef struct packed {
    logic sub;
    logic [2*MAX_WIDTH-1:0] val;
  } row_t;
  // The top row of a signed multiply carries negative weight, so it is subtracted.
  function automatic row_t pp_row(input logic [MAX_WIDTH-1:0] a, input logic b_bit, input int k,
                                  input logic sgn, input int width);
    row_t r;
    logic [2*MAX_WIDTH-1:0] mask, ext;
    mask = (32'd1 << width) - 32'd1;
    ext = {{MAX_WIDTH{1'b0}}, a} & mask;
    ext = (sgn && a[4'(width-1)]) ? (ext | ~mask) : ext;
    r.sub = sgn && (k == width - 1);
    r.val = b_bit ? (ext << k) : '0;
    return r;
  endfunction
endpackage

// File: rtl/pp_stage.sv
// pp_stage: one pipeline stage that accumulates partial-product row K into the running sum.
module pp_stage
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int K = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               prev_valid,
  input  logic               prev_sgn,
  input  logic [WIDTH-1:0]   prev_a,
  input  logic [WIDTH-1:0]   prev_b,
  input  logic [2*WIDTH-1:0] prev_sum,
  output logic               valid,
  output logic               sgn,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] sum
);
  row_t r;
  logic [2*WIDTH-1:0] row, next_sum;
  logic unused_row;
  always_comb begin
    r = pp_row(MAX_WIDTH'(prev_a), prev_b[K], K, prev_sgn, WIDTH);
    row = r.val[2*WIDTH-1:0];
    next_sum = r.sub ? prev_sum - row : prev_sum + row;
  end
  assign unused_row = ^r.val;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      sgn <= 1'b0;
      a <= '0;
      b <= '0;
      sum <= '0;
    end else if (en) begin
      valid <= prev_valid;
      sgn <= prev_sgn;
      a <= prev_a;
      b <= prev_b;
      sum <= next_sum;
    end
  end
endmodule

// File: rtl/pipelined_array_multiplier_param.sv
// pipelined_array_multiplier_param: WIDTH-stage array multiplier, one row per stage, per-pair signedness.
module pipelined_array_multiplier_param
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] y
);
  logic               v  [WIDTH+1];
  logic               s  [WIDTH+1];
  logic [WIDTH-1:0]   av [WIDTH+1];
  logic [WIDTH-1:0]   bv [WIDTH+1];
  logic [2*WIDTH-1:0] sm [WIDTH+1];
  logic unused_tail;
  assign v[0] = in_valid;
  assign s[0] = sgn;
  assign av[0] = a;
  assign bv[0] = b;
  assign sm[0] = '0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    pp_stage #(.WIDTH(WIDTH), .K(i)) u_stage (
      .clk(clk), .rst(rst), .en(en),
      .prev_valid(v[i]), .prev_sgn(s[i]), .prev_a(av[i]), .prev_b(bv[i]), .prev_sum(sm[i]),
      .valid(v[i+1]), .sgn(s[i+1]), .a(av[i+1]), .b(bv[i+1]), .sum(sm[i+1])
    );
  end
  assign out_valid = v[WIDTH];
  assign y = v[WIDTH] ? sm[WIDTH] : '0;
  assign unused_tail = ^{s[WIDTH], av[WIDTH], bv[WIDTH]};
endmodule

// File: tb/tb_pipelined_array_multiplier_param.sv
// tb_pipelined_array_multiplier_param: scoreboard bench driving WIDTH=4 and WIDTH=8 instances in lockstep.
module tb_pipelined_array_multiplier_param;
  logic clk = 0, rst = 0, en = 0, in_valid = 0, sgn = 0;
  logic [7:0] a = 0, b = 0;
  logic ov4, ov8;
  logic [7:0] y4;
  logic [15:0] y8;
  typedef struct {
    logic [15:0] p;
    int e;
  } exp_t;
  exp_t q4[$], q8[$];
  int ecnt = 0, checks = 0, fails = 0;
  bit live = 0, stalled = 0;
  logic pov4 = 0, pov8 = 0;
  logic [7:0] py4 = 0;
  logic [15:0] py8 = 0;

  always #5 clk = ~clk;

  pipelined_array_multiplier_param #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sgn(sgn),
    .a(a[3:0]), .b(b[3:0]), .out_valid(ov4), .y(y4)
  );
  pipelined_array_multiplier_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sgn(sgn),
    .a(a), .b(b), .out_valid(ov8), .y(y8)
  );

  // Reference: interpret operands as integers and multiply, modulo 2^(2w).
  function automatic logic [15:0] ref_mul(input int w, input logic s, input logic [7:0] x, input logic [7:0] z);
    int xa, za;
    xa = int'(x) & ((1 << w) - 1);
    za = int'(z) & ((1 << w) - 1);
    if (s && xa >= (1 << (w - 1))) xa -= (1 << w);
    if (s && za >= (1 << (w - 1))) za -= (1 << w);
    return 16'((xa * za) & ((1 << (2 * w)) - 1));
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  always @(posedge clk) begin
    stalled = !rst && !en;
    if (rst) begin
      q4.delete();
      q8.delete();
      live = 1;
    end else if (en) begin
      ecnt++;
      if (in_valid) begin
        q4.push_back('{ref_mul(4, sgn, a, b), ecnt});
        q8.push_back('{ref_mul(8, sgn, a, b), ecnt});
      end
    end
  end

  always @(negedge clk) if (live) begin
    if (stalled) begin
      check("hold_valid4", 32'(ov4), 32'(pov4));
      check("hold_y4", 32'(y4), 32'(py4));
    end else if (ov4) begin
      if (q4.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL spurious4: out_valid=1 y=%0h, expected no product", y4);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("product4", 32'(y4), 32'(e.p));
        check("latency4", 32'(ecnt - e.e), 32'd3);
      end
    end else check("idle_y4", 32'(y4), 32'd0);
    pov4 = ov4;
    py4 = y4;
  end

  always @(negedge clk) if (live) begin
    if (stalled) begin
      check("hold_valid8", 32'(ov8), 32'(pov8));
      check("hold_y8", 32'(y8), 32'(py8));
    end else if (ov8) begin
      if (q8.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL spurious8: out_valid=1 y=%0h, expected no product", y8);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("product8", 32'(y8), 32'(e.p));
        check("latency8", 32'(ecnt - e.e), 32'd7);
      end
    end else check("idle_y8", 32'(y8), 32'd0);
    pov8 = ov8;
    py8 = y8;
  end

  task automatic drive(input bit r, input bit e, input bit iv, input bit s, input logic [7:0] x, input logic [7:0] z);
    @(posedge clk);
    #2;
    rst = r;
    en = e;
    in_valid = iv;
    sgn = s;
    a = x;
    b = z;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 1, 0, 0, 8'd0, 8'd0);
  endtask

  initial begin
    drive(1, 0, 1, 1, 8'hff, 8'hff);
    drive(1, 1, 1, 0, 8'hff, 8'hff);
    idle(1);
    @(negedge clk);
    check("reset_valid4", 32'(ov4), 32'd0);
    check("reset_y4", 32'(y4), 32'd0);
    check("reset_valid8", 32'(ov8), 32'd0);
    idle(12);
    drive(0, 1, 1, 0, 8'd15, 8'd15);
    drive(0, 1, 1, 0, 8'd15, 8'd12);
    drive(0, 1, 1, 0, 8'd2, 8'd15);
    idle(10);
    drive(0, 1, 1, 1, 8'd8, 8'd8);
    drive(0, 1, 1, 1, 8'd8, 8'd7);
    drive(0, 1, 1, 1, 8'd15, 8'd1);
    drive(0, 1, 1, 0, 8'd15, 8'd15);
    idle(10);
    drive(0, 1, 1, 0, 8'd3, 8'd5);
    drive(0, 1, 0, 0, 8'd0, 8'd0);
    drive(0, 1, 1, 0, 8'd7, 8'd7);
    drive(0, 1, 0, 0, 8'd0, 8'd0);
    repeat (3) drive(0, 0, 1, 0, 8'd9, 8'd9);
    idle(10);
    drive(0, 1, 1, 0, 8'd5, 8'd6);
    drive(0, 1, 1, 1, 8'd9, 8'd3);
    drive(1, 1, 1, 0, 8'd4, 8'd4);
    idle(12);
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++)
        for (int z = 0; z < 16; z++)
          drive(0, 1, 1, s[0], 8'(x), 8'(z));
    idle(10);
    repeat (10000)
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom));
    idle(12);
    @(negedge clk);
    check("drain4", 32'(q4.size()), 32'd0);
    check("drain8", 32'(q8.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/pipelined_array_multiplier_param.md
# pipelined_array_multiplier_param

Parametrised, fully pipelined array multiplier, the successor to the fixed 4×4 pipelined multiplier. It has the following features:
- Operand width is set by `WIDTH`.
- Each partial-product row is accumulated in its own registered stage.
- A valid bit travels alongside each operand pair, and a global clock enable stalls the whole pipeline.
- Unsigned or two's-complement multiplication is selected per operand pair.

It sits in the datapath as a drop-in multiply unit that accepts one new operand pair per cycle.

## Interface
- `WIDTH`, default 4: operand width in bits; legal range 2..16.
- `clk` input 1: clock; all state updates on its rising edge.
- `rst` input 1: reset; synchronous and active-high.
- `en` input 1: pipeline enable; when low, every pipeline register holds.
- `in_valid` input 1: the current `a`/`b`/`sgn` form a new operand pair.
- `sgn` input 1: 1 = both operands two's complement, 0 = both unsigned.
- `a` input WIDTH: multiplicand.
- `b` input WIDTH: multiplier.
- `out_valid` output 1: `y` holds a finished product.
- `y` output 2*WIDTH: product; two's complement when the pair's `sgn` was 1.

## Operation
- The pipeline has `WIDTH` stages, S0..S(WIDTH-1). Each stage holds:
  - a valid bit;
  - the pair's `sgn`;
  - `a` and `b`, carried along;
  - a 2*WIDTH-bit partial sum.
- On an edge with `en`=1, S0 captures `in_valid`, `sgn`, `a`, `b` and partial sum = row 0.
- On an edge with `en`=1, S(k) loads S(k-1) plus row k, for k ≥ 1.
- Row k is defined as follows:
  - Unsigned: (`b`[k] ? zero-extended `a` : 0) << k.
  - Signed, k < WIDTH-1: (`b`[k] ? sign-extended `a` : 0) << k.
  - Signed, k = WIDTH-1: the row is subtracted, not added (weight of the `b` sign bit is negative).
- All arithmetic is modulo 2^(2*WIDTH). The full-range results fit exactly:
  - unsigned max: (2^W-1)^2;
  - signed (-2^(W-1))^2 = +2^(2W-2).
- `out_valid` = valid bit of S(WIDTH-1).
- `y` = partial sum of S(WIDTH-1) when `out_valid`=1, otherwise 0 (combinational gate on the output).
- `in_valid`=0 inserts a bubble. The bubble travels with a cleared valid bit, and its data is not observable on `y`.
- `sgn` is carried per pair, so mixed signed and unsigned pairs may be issued back-to-back.

## Timing
- Reset: on an edge with `rst`=1, all valid bits and partial sums clear to 0. `rst` takes priority over `en`.
  - Output after reset: `out_valid`=0, `y`=0 from the next cycle.
  - Operand and `sgn` registers also clear to 0.
- Latency:
  - A pair presented with `in_valid`=1 and captured at enabled edge E appears with `out_valid`=1 after enabled edge E+WIDTH-1.
  - That is `WIDTH` enabled edges including the capture edge: 4 cycles for `WIDTH`=4.
- Throughput: one pair per enabled cycle, with no back-pressure other than `en`.
- Stall:
  - While `en`=0, inputs are ignored and nothing is captured.
  - All stages, `out_valid` and `y` hold their values.
  - Latency is counted only in enabled edges.
- Reset mid-operation: every in-flight pair is discarded, and no product for it ever appears.
- Reset and `in_valid` together: the pair is dropped.

## Structure
- Shared package `mult_pkg` holds:
  - the default `WIDTH`;
  - a function `pp_row(a, b_bit, k, sgn, width)` returning the row value and the add/subtract sense.
- One sub-module, `pp_stage`:
  - contains one adder/subtractor plus the stage registers (valid, `sgn`, `a`, `b`, sum);
  - takes `en` and `rst`;
  - is instantiated `WIDTH` times with a generate loop and a stage-index parameter.
- The top level holds the stage chain and the output gating only.

## Test plan
All scenarios use `WIDTH`=4 unless noted.
- Reset, then idle: `out_valid`=0 and `y`=0 for at least 10 cycles.
- Unsigned back-to-back pairs 15×15, 15×12, 2×15 on consecutive edges:
  - `y` = 225, 180, 30;
  - on 3 consecutive cycles;
  - the first appearing 4 edges after the first capture.
- Signed pairs, issued back-to-back with an unsigned 15×15:
  - -8×-8 → 64 (0x40);
  - -8×7 → -56 (0xC8);
  - -1×1 → 0xFF;
  - the 15×15 gives 225 (0xE1), confirming the per-pair `sgn`.
- Bubble and stall:
  - Issue 3×5, a bubble, then 7×7.
  - Drop `en` for 3 cycles while the pairs are in flight.
  - Required: outputs 15, one invalid cycle, then 49; `y` and `out_valid` frozen during the stall; latency extended by exactly 3.
- Reset mid-flight: assert `rst` with 2 pairs in flight → neither product ever appears, and `out_valid`=0 until new inputs arrive.
- Exhaustive checks:
  - `WIDTH`=8: random 10k pairs with random `sgn`, `in_valid` and `en`, compared against a scoreboard model.
  - `WIDTH`=4: sweep all 256×2 operand/`sgn` combinations.
